pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline (IF,ID,EX,ME,WB).

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/ctrl_downcnt.sv | 23 ++
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage indices,
// controller state encoding and per-stage hold/bubble masks (bit0=IF .. bit4=WB).
package pipe_pkg;

    localparam int unsigned ST_IF = 0;
    localparam int unsigned ST_ID = 1;
    localparam int unsigned ST_EX = 2;
    localparam int unsigned ST_ME = 3;
    localparam int unsigned ST_WB = 4;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_MDU = 2'd1,
        S_MEM = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] MSK_NONE   = 5'b00000;
    localparam logic [4:0] MSK_ALL    = 5'b11111;
    localparam logic [4:0] STALL_MEMW = 5'b01111;
    localparam logic [4:0] FLUSH_MEMW = 5'b10000;
    localparam logic [4:0] STALL_MDU  = 5'b00111;
    localparam logic [4:0] FLUSH_MDU  = 5'b01000;
    localparam logic [4:0] STALL_LU   = 5'b00011;
    localparam logic [4:0] FLUSH_LU   = 5'b00100;
    localparam logic [4:0] FLUSH_BR   = 5'b00010;

endpackage

// File: rtl/ctrl_downcnt.sv
// Loadable down-counter that saturates at zero; tracks remaining MUL/DIV cycles.
module ctrl_downcnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, MUL/DIV,
// data-memory wait and branch requests into Mealy per-stage stall/flush/PC-write.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned MEM_TMO    = 255,
    parameter int unsigned CNT_W      = 8,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_pause,
    input  logic       id_br_taken,
    input  logic       ex_mdu_start,
    input  logic       ex_mdu_div,
    input  logic       me_mem_req,
    input  logic       me_mem_ack,
    output logic [4:0] stall_o,
    output logic [4:0] flush_o,
    output logic       pc_we_o,
    output logic       mdu_busy_o,
    output logic       mem_err_o,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TMO);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    ctrl_state_t      state, state_nxt;
    logic [CNT_W-1:0] mcnt, mcnt_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_ld_val;
    logic             tmo, memw, mdu_issue, mdu_hold, dcnt_ld, dcnt_dec;

    assign tmo         = (state == S_MEM) && (mcnt == TMO_VAL);
    assign memw        = me_mem_req & ~me_mem_ack & ~tmo;
    assign mdu_issue   = (state == S_RUN) & ex_mdu_start;
    // The MDU keeps running through a memory wait, so its hold survives in S_MEM.
    assign mdu_hold    = mdu_issue | (state == S_MDU) | ((state == S_MEM) & (dcnt != '0));
    assign dcnt_ld     = mdu_issue & ~memw;
    assign dcnt_ld_val = ex_mdu_div ? DIV_LD : MUL_LD;
    assign dcnt_dec    = (state != S_RUN);

    ctrl_downcnt #(.CNT_W(CNT_W)) u_dcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dcnt_ld),
        .load_val (dcnt_ld_val),
        .dec      (dcnt_dec),
        .cnt      (dcnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            mcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        unique case (state)
            S_RUN: begin
                if (memw) begin
                    state_nxt = S_MEM;
                    mcnt_nxt  = ONE;
                end else if (ex_mdu_start && (dcnt_ld_val != '0)) begin
                    state_nxt = S_MDU;
                end
            end
            S_MDU: begin
                if (memw) begin
                    state_nxt = S_MEM;
                    mcnt_nxt  = ONE;
                end else if (dcnt <= ONE) begin
                    state_nxt = S_RUN;
                end
            end
            S_MEM: begin
                if (memw) begin
                    mcnt_nxt = (mcnt != '1) ? mcnt + 1'b1 : mcnt;
                end else begin
                    // Resume MDU only if cycles remain after this one's decrement.
                    state_nxt = (dcnt > ONE) ? S_MDU : S_RUN;
                    mcnt_nxt  = '0;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        stall_o   = MSK_NONE;
        flush_o   = MSK_NONE;
        pc_we_o   = 1'b1;
        mem_err_o = 1'b0;
        if (memw) begin
            stall_o = STALL_MEMW;
            flush_o = FLUSH_MEMW;
            pc_we_o = 1'b0;
        end else if (mdu_hold) begin
            stall_o = STALL_MDU;
            flush_o = FLUSH_MDU;
            pc_we_o = 1'b0;
        end else if (id_pause) begin
            stall_o = STALL_LU;
            flush_o = FLUSH_LU;
            pc_we_o = 1'b0;
        end else if (id_br_taken) begin
            flush_o = DELAY_SLOT ? MSK_NONE : FLUSH_BR;
        end
        if (tmo) begin
            flush_o[ST_ME] = 1'b1;
            mem_err_o      = 1'b1;
        end
        if (!rst) begin
            stall_o   = MSK_NONE;
            flush_o   = MSK_ALL;
            pc_we_o   = 1'b0;
            mem_err_o = 1'b0;
        end
    end

    assign mdu_busy_o = rst & (state == S_MDU);
    assign state_o    = state;

endmodule
